axi_busy_rr_arbiter: RTL and testbench
======================================

Name: axi_busy_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream AXI channel (e.g. slave AW/W path) between NUM_REQ upstream requesters.
- A grant is held for a whole transaction. It is released on the falling edge of the granted requester's busy flag, detected inside the block with a registered previous-value compare.
- A hold watchdog forces release if a transaction never completes.
- Sits in the interconnect between master-side request logic and the shared slave-side mux select.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(NUM_REQ), width of grant index.
- MAX_HOLD, 256, max cycles in ACTIVE before forced release (>=2).
- CNT_W, $clog2(MAX_HOLD+1), hold counter width.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- ARESETN  input  1  synchronous active-low reset, sampled on rising ACLK.
- req  input  NUM_REQ  per-requester access request, level.
- busy  input  NUM_REQ  per-requester transaction-in-flight flag; a 1->0 transition marks completion.
- grant  output  NUM_REQ  one-hot grant, registered; all-zero when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_idx  output  IDX_W  index of current/last grantee, registered.
- release_pulse  output  1  one-cycle pulse when a grant is released normally.
- timeout_pulse  output  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Reset (ARESETN=0 at a clock edge):
  - grant=0, grant_valid=0, grant_idx=0, release_pulse=0, timeout_pulse=0.
  - State=IDLE, hold counter=0, busy_q=0.
  - rr pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transaction drops grant in the same edge; no release/timeout pulse is generated.
- busy_q <= busy every cycle.
  - fall[i] = busy_q[i] & ~busy[i], combinational from the registered value.
- States: IDLE, GRANTED, ACTIVE.
- IDLE:
  - If req!=0, pick the first set bit searching from ptr+1 upward, with wraparound.
  - grant/grant_idx/grant_valid are registered: grant visible 1 cycle after req is first sampled.
  - Next state GRANTED.
- GRANTED (waiting for transaction start):
  - If busy[idx]=1, go to ACTIVE and clear the counter.
  - Else if req[idx]=0 (request withdrawn), clear grant, go to IDLE, ptr<=idx; no pulses.
  - Else hold.
- ACTIVE:
  - Counter increments each cycle.
  - If fall[idx]=1: clear grant next edge, release_pulse=1 for that cycle, ptr<=idx, go to IDLE.
  - Else if counter==MAX_HOLD-1: clear grant, timeout_pulse=1, ptr<=idx, go to IDLE.
  - Fall and timeout in the same cycle: normal release wins; timeout_pulse stays 0.
- Back-to-back: after release, IDLE arbitrates on the next cycle. Minimum 1 idle cycle between grants (grant low for exactly one cycle).
- Busy/falling edges on non-granted requesters are ignored.
- req changes while in GRANTED/ACTIVE do not affect the current grant; only req[idx] in GRANTED matters.
- grant is always one-hot or zero. grant_idx holds its last value when grant=0.
- Counter saturates logic-free: it cannot exceed MAX_HOLD-1 because the block exits.

Decomposition:
- Shared package axi_arb_pkg:
  - State enum: ARB_IDLE=2'd0, ARB_GRANTED=2'd1, ARB_ACTIVE=2'd2.
  - Default MAX_HOLD constant.
- One sub-module, busy_fall_detect:
  - Parameterised width NUM_REQ, synchronous active-low reset.
  - Registers busy and outputs fall vector.
  - Instantiated once.
- Round-robin priority search stays inline (function).

Test Plan:
- Reset then req=4'b0001 → grant=0001 one cycle later, grant_idx=0. Then busy[0] high 3 cycles, then low → release_pulse=1 the cycle grant drops, grant=0.
- req=4'b1111 continuously, each grantee completes one busy pulse → grant order 0,1,2,3,0, each separated by exactly one grant-low cycle.
- Grant 2, then req[2] drops while busy[2]=0 → grant cleared next edge, no release_pulse or timeout_pulse. Next req=4'b0110 grants 1 (pointer=2 → search 3,0,1).
- MAX_HOLD=8, grant 1, busy[1] stuck high → timeout_pulse after 8 ACTIVE cycles, grant=0. A later req=4'b0011 grants 0.
- Grant 0 ACTIVE, pulse busy[3] high→low → no release; grant stays 0001 until busy[0] falls.
- ARESETN low for one cycle while ACTIVE on requester 3 → all outputs 0 next edge, no pulses. After reset, req=4'b1000 grants 3 and req=4'b1001 grants 0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the busy-released round-robin AXI arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_ACTIVE  = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_HOLD_DEF = 256;

endpackage

// File: rtl/busy_fall_detect.sv
// Registers the per-requester busy flags and flags 1->0 transitions.
// fall_o is combinational from the registered value; no backpressure.
module busy_fall_detect #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] busy_i,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_i;
    end

    assign fall_o = busy_q & ~busy_i;

endmodule

// File: rtl/axi_busy_rr_arbiter.sv
// Round-robin arbiter holding a grant for a whole busy transaction; grant is
// registered (1 cycle after req), released on busy fall or hold watchdog.
module axi_busy_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] busy,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               release_pulse,
    output logic               timeout_pulse
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               gv_q, gv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rel_q, rel_d;
    logic               tmo_q, tmo_d;
    logic [NUM_REQ-1:0] fall;

    // First set request strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               c;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(p) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && r[c]) begin
                pick  = IDX_W'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    busy_fall_detect #(.W(NUM_REQ)) u_fall (
        .clk_i  (ACLK),
        .rst_ni (ARESETN),
        .busy_i (busy),
        .fall_o (fall)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= ARB_IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:    if (|req) state_d = ARB_GRANTED;
            ARB_GRANTED: begin
                if (busy[idx_q])      state_d = ARB_ACTIVE;
                else if (!req[idx_q]) state_d = ARB_IDLE;
            end
            ARB_ACTIVE:  if (fall[idx_q] || cnt_q == HOLD_LAST) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        rel_d   = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    grant_d = NUM_REQ'(1) << idx_d;
                end
            end
            ARB_GRANTED: begin
                if (busy[idx_q]) begin
                    cnt_d = '0;
                end else if (!req[idx_q]) begin
                    grant_d = '0;
                    ptr_d   = idx_q;
                end
            end
            ARB_ACTIVE: begin
                cnt_d = cnt_q + 1'b1;
                // Normal completion takes precedence over a coincident watchdog expiry.
                if (fall[idx_q]) begin
                    grant_d = '0;
                    rel_d   = 1'b1;
                    ptr_d   = idx_q;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    grant_d = '0;
                    tmo_d   = 1'b1;
                    ptr_d   = idx_q;
                    cnt_d   = '0;
                end
            end
            default: grant_d = '0;
        endcase
        gv_d = |grant_d;
    end

    assign grant         = grant_q;
    assign grant_valid   = gv_q;
    assign grant_idx     = idx_q;
    assign release_pulse = rel_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_axi_busy_rr_arbiter.sv
// Directed + random bench for axi_busy_rr_arbiter with a transaction-level reference model.
module tb_axi_busy_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
    localparam int IW = 2;

    logic          ACLK    = 1'b0;
    logic          ARESETN = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N-1:0]  busy    = '0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          release_pulse;
    logic          timeout_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the channel, whether their transaction began,
    // how long it has run, and whose turn was last.
    int       m_owner = -1;
    bit       m_started = 0;
    int       m_hold = 0;
    int       m_last = N - 1;
    int       m_gidx = 0;
    bit [N-1:0] m_prev = '0;
    bit       m_rel = 0;
    bit       m_tmo = 0;

    axi_busy_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req           (req),
        .busy          (busy),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .release_pulse (release_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic [N-1:0] r, input logic [N-1:0] b);
        if (!rst_n) begin
            m_owner = -1; m_started = 0; m_hold = 0; m_last = N - 1;
            m_gidx = 0; m_prev = '0; m_rel = 0; m_tmo = 0;
            return;
        end
        m_rel = 0;
        m_tmo = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_gidx = m_owner;
                m_started = 0;
            end
        end else if (!m_started) begin
            if (b[m_owner]) begin
                m_started = 1;
                m_hold = 0;
            end else if (!r[m_owner]) begin
                m_last = m_owner;
                m_owner = -1;
            end
        end else begin
            if (m_prev[m_owner] && !b[m_owner]) begin
                m_rel = 1; m_last = m_owner; m_owner = -1;
            end else if (m_hold == MH - 1) begin
                m_tmo = 1; m_last = m_owner; m_owner = -1;
            end else begin
                m_hold++;
            end
        end
        m_prev = b;
    endtask

    // One clock: model consumes the inputs present at the edge, outputs compared 1ns later.
    task automatic cyc();
        logic         rs;
        logic [N-1:0] r, b, eg;
        rs = ARESETN; r = req; b = busy;
        @(posedge ACLK);
        model_edge(rs, r, b);
        #1;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
        chk("release_pulse", 32'(release_pulse), 32'(m_rel));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tmo));
    endtask

    task automatic do_reset();
        ARESETN = 1'b0; req = '0; busy = '0;
        cyc(); cyc();
        ARESETN = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);

        // Single requester, busy for 3 cycles, normal release
        req = 4'b0001; cyc();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_idx", 32'(grant_idx), 32'h0);
        busy = 4'b0001; cyc(); cyc(); cyc();
        busy = 4'b0000; req = 4'b0000; cyc();
        chk("t1_rel", 32'(release_pulse), 32'h1);
        chk("t1_drop", 32'(grant), 32'h0);
        cyc();

        // Round-robin order 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("rr_idx", 32'(grant_idx), 32'(n % N));
            busy = N'(1) << (n % N); cyc();
            busy = '0; cyc();
            chk("rr_gap", 32'(grant), 32'h0);
        end
        req = '0; cyc();

        // Withdrawal before start, then pointer continues after requester 2
        req = 4'b0100; cyc();
        chk("wd_grant", 32'(grant), 32'h4);
        req = 4'b0000; cyc();
        chk("wd_drop", 32'(grant), 32'h0);
        chk("wd_norel", 32'(release_pulse | timeout_pulse), 32'h0);
        req = 4'b0110; cyc();
        chk("wd_next", 32'(grant), 32'h2);
        req = 4'b0000; cyc();

        // Watchdog: busy[1] stuck high
        req = 4'b0010; cyc();
        busy = 4'b0010; req = 4'b0000; cyc();
        for (int k = 0; k < MH - 1; k++) begin
            cyc();
            chk("to_early", 32'(timeout_pulse), 32'h0);
        end
        cyc();
        chk("to_pulse", 32'(timeout_pulse), 32'h1);
        chk("to_drop", 32'(grant), 32'h0);
        busy = 4'b0000; req = 4'b0011; cyc();
        chk("to_next", 32'(grant), 32'h1);
        req = 4'b0000; cyc();

        // Fall on a non-granted requester is ignored
        req = 4'b0001; cyc();
        busy = 4'b0001; req = 4'b0000; cyc();
        busy = 4'b1001; cyc();
        busy = 4'b0001; cyc();
        chk("ng_hold", 32'(grant), 32'h1);
        chk("ng_norel", 32'(release_pulse), 32'h0);
        busy = 4'b0000; cyc();
        chk("ng_rel", 32'(release_pulse), 32'h1);
        cyc();

        // Reset in the middle of a transaction on requester 3
        req = 4'b1000; cyc();
        busy = 4'b1000; cyc(); cyc();
        ARESETN = 1'b0; cyc();
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_pulses", 32'(release_pulse | timeout_pulse), 32'h0);
        ARESETN = 1'b1; busy = 4'b0000; cyc();
        req = 4'b1000; cyc();
        chk("mr_g3", 32'(grant_idx), 32'h3);
        req = 4'b0000; cyc();
        req = 4'b1001; cyc();
        chk("mr_g0", 32'(grant), 32'h1);
        req = 4'b0000; cyc();

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            ARESETN = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) req = '0;
            else if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 15));
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 3) == 0) busy[j] = ~busy[j];
            if ($urandom_range(0, 9) < 7 && m_owner >= 0 && m_started)
                busy[m_owner] = busy[m_owner] | ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
